// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and the blocks that read it.
// FIFO_RD_LAT is the cycles from a sampled `rd` to valid `data_out`.
package fifo_pkg;
   localparam int DATA_WIDTH  = 8;
   localparam int FIFO_RD_LAT = 1;
   typedef logic [DATA_WIDTH-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_stream_reader_chk.sv
// Design-intent assertions for fifo_stream_reader (credit safety, FIFO contract).
module fifo_stream_reader_chk
   import fifo_pkg::*;
#(
   parameter int BUF_DEPTH = 4,
   localparam int AW       = $clog2(BUF_DEPTH)
)(
   input logic          clock,
   input logic          rst,
   input logic          fifo_rd,
   input logic          fifo_empty,
   input logic          capture,
   input logic [AW:0]   buf_count
);

   no_overflow: assert property (@(posedge clock) disable iff (rst)
      !(capture && (buf_count == (AW+1)'(BUF_DEPTH))));

   no_empty_read: assert property (@(posedge clock) disable iff (rst)
      !(fifo_rd && fifo_empty));

   read_lands: assert property (@(posedge clock) disable iff (rst)
      fifo_rd |-> ##FIFO_RD_LAT capture);

endmodule

// File: rtl/stream_skid_buf.sv
// Circular skid buffer: one write port, one pop port, occupancy count and head word.
// Callers never pop when empty nor write when full without a matching pop.
module stream_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
   parameter int DEPTH      = 4,
   localparam int AW        = $clog2(DEPTH)
)(
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  pop,
   output logic [AW:0]           count,
   output logic [DATA_WIDTH-1:0] head
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count_next;

   // Occupancy follows write/pop; both at once leaves it unchanged.
   always_comb begin
      count_next = count;
      case ({wr_en, pop})
         2'b10:   count_next = count + (AW+1)'(1);
         2'b01:   count_next = count - (AW+1)'(1);
         default: count_next = count;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
      end
   end

   // Storage carries no reset; stale contents are never exposed as valid.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read master that re-presents popped words on a valid/ready stream,
// hiding the FIFO's registered read latency behind a credit-managed skid buffer.
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
   parameter int BUF_DEPTH  = 4,
   parameter int CNT_WIDTH  = 16
)(
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_rd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  pop_count
);

   localparam int AW = $clog2(BUF_DEPTH);

   logic          inflight;
   logic [AW:0]   buf_count;
   logic [AW+1:0] credits_used;
   logic          transfer;

   // An in-flight read already owns a buffer slot, so it counts against credit.
   assign credits_used = {1'b0, buf_count} + {{(AW+1){1'b0}}, inflight};
   assign fifo_rd      = !rst && en && !fifo_empty && (credits_used < (AW+2)'(BUF_DEPTH));
   assign out_valid    = !rst && (buf_count != '0);
   assign transfer     = out_valid && out_ready;
   assign busy         = !rst && (inflight || (buf_count != '0));

   // Track the read issued last cycle and count words accepted by the sink.
   always_ff @(posedge clock) begin
      if (rst) begin
         inflight  <= 1'b0;
         pop_count <= '0;
      end else begin
         inflight <= fifo_rd;
         if (transfer) pop_count <= pop_count + CNT_WIDTH'(1);
      end
   end

   stream_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BUF_DEPTH)
   ) u_buf (
      .clock   (clock),
      .rst     (rst),
      .wr_en   (inflight),
      .wr_data (fifo_data_out),
      .pop     (transfer),
      .count   (buf_count),
      .head    (out_data)
   );

   fifo_stream_reader_chk #(
      .BUF_DEPTH (BUF_DEPTH)
   ) u_chk (
      .clock      (clock),
      .rst        (rst),
      .fifo_rd    (fifo_rd),
      .fifo_empty (fifo_empty),
      .capture    (inflight),
      .buf_count  (buf_count)
   );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds the DUT and
// scenario tasks check stream timing, ordering, stalls, enable and reset.
module tb_fifo_stream_reader;
   localparam int DW = 8;
   localparam int CW = 16;

   logic          clock = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data_out = '0;
   logic          fifo_rd;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          busy;
   logic [CW-1:0] pop_count;

   logic          push_valid = 1'b0;
   logic [DW-1:0] push_data = '0;
   logic [DW-1:0] fifo_q [$];
   logic [CW-1:0] exp_pop = '0;
   int            checks = 0;
   int            failures = 0;

   always #5 clock = ~clock;

   fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(4), .CNT_WIDTH(CW)) dut (
      .clock(clock), .rst(rst), .en(en), .fifo_empty(fifo_empty),
      .fifo_data_out(fifo_data_out), .fifo_rd(fifo_rd), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy), .pop_count(pop_count)
   );

   // Synchronous FIFO model: registered read data, one push per clock.
   always @(posedge clock) begin
      if (rst) begin
         fifo_q.delete();
         fifo_empty <= 1'b1;
      end else begin
         if (fifo_rd && fifo_q.size() != 0) fifo_data_out <= fifo_q.pop_front();
         if (push_valid) fifo_q.push_back(push_data);
         fifo_empty <= (fifo_q.size() == 0);
      end
   end

   task automatic push_one(input logic [DW-1:0] w);
      @(negedge clock);
      push_valid = 1'b1;
      push_data  = w;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      #1;
      checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", fifo_rd); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b0;
      @(negedge clock); #1;
      checks++; if (pop_count !== 16'd0) begin failures++; $display("FAIL reset_popcnt got=%0d exp=0", pop_count); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_empty();
      en = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock); #1;
         checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL empty_rd cyc=%0d got=%b exp=0", c, fifo_rd); end
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_valid cyc=%0d got=%b exp=0", c, out_valid); end
      end
      checks++; if (pop_count !== exp_pop) begin failures++; $display("FAIL empty_popcnt got=%0d exp=%0d", pop_count, exp_pop); end
      en = 1'b0;
   endtask

   task automatic test_basic();
      logic [DW-1:0] words [3];
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
      en = 1'b0;
      for (int i = 0; i < 3; i++) push_one(words[i]);
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (c == 0) begin push_valid = 1'b0; en = 1'b1; out_ready = 1'b1; end
         #1;
         checks++; if (fifo_rd !== 1'(c < 3)) begin failures++; $display("FAIL basic_rd cyc=%0d got=%b exp=%b", c, fifo_rd, 1'(c < 3)); end
         checks++; if (out_valid !== 1'(c >= 2 && c <= 4)) begin failures++; $display("FAIL basic_valid cyc=%0d got=%b", c, out_valid); end
         if (c >= 2 && c <= 4) begin
            checks++; if (out_data !== words[c-2]) begin failures++; $display("FAIL basic_data cyc=%0d got=%h exp=%h", c, out_data, words[c-2]); end
         end
      end
      exp_pop += 16'd3;
      checks++; if (pop_count !== exp_pop) begin failures++; $display("FAIL basic_popcnt got=%0d exp=%0d", pop_count, exp_pop); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", busy); end
   endtask

   task automatic test_stall();
      int rd_pulses = 0;
      int idx = 0;
      en = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 10; i++) push_one(DW'(i));
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         if (c == 0) begin push_valid = 1'b0; en = 1'b1; end
         #1;
         if (fifo_rd) rd_pulses++;
         checks++; if (fifo_rd !== 1'(c < 4)) begin failures++; $display("FAIL stall_rd cyc=%0d got=%b exp=%b", c, fifo_rd, 1'(c < 4)); end
         if (c >= 2) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin failures++; $display("FAIL stall_hold cyc=%0d valid=%b data=%h exp=1/00", c, out_valid, out_data); end
         end
      end
      checks++; if (rd_pulses != 4) begin failures++; $display("FAIL stall_rd_count got=%0d exp=4", rd_pulses); end
      for (int r = 0; r < 40 && idx < 10; r++) begin
         @(negedge clock);
         out_ready = 1'b1;
         #1;
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_gap cyc=%0d got=%b exp=1", r, out_valid); end
         if (out_valid) begin
            checks++; if (out_data !== DW'(idx)) begin failures++; $display("FAIL stall_order got=%h exp=%h", out_data, DW'(idx)); end
            idx++;
         end
      end
      checks++; if (idx != 10) begin failures++; $display("FAIL stall_budget got=%0d exp=10", idx); end
      exp_pop += 16'd10;
      @(negedge clock); #1;
      checks++; if (pop_count !== exp_pop) begin failures++; $display("FAIL stall_popcnt got=%0d exp=%0d", pop_count, exp_pop); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_busy got=%b exp=0", busy); end
   endtask

   task automatic test_random();
      logic [DW-1:0] ref_q [$];
      logic [DW-1:0] w;
      logic [DW-1:0] exp_w;
      int pushed = 0;
      int got = 0;
      en = 1'b1;
      for (int c = 0; c < 4000 && got < 200; c++) begin
         @(negedge clock);
         push_valid = 1'b0;
         if (pushed < 200 && $urandom_range(0, 1) == 1) begin
            w = DW'($urandom);
            push_valid = 1'b1; push_data = w;
            ref_q.push_back(w);
            pushed++;
         end
         out_ready = 1'($urandom_range(0, 1));
         #1;
         checks++; if (fifo_rd && fifo_empty) begin failures++; $display("FAIL rand_rd_empty cyc=%0d rd=%b empty=%b", c, fifo_rd, fifo_empty); end
         if (out_valid && out_ready) begin
            checks++; got++;
            if (ref_q.size() == 0) begin
               failures++; $display("FAIL rand_extra got=%h exp=none", out_data);
            end else begin
               exp_w = ref_q.pop_front();
               if (out_data !== exp_w) begin failures++; $display("FAIL rand_order idx=%0d got=%h exp=%h", got - 1, out_data, exp_w); end
            end
         end
      end
      push_valid = 1'b0;
      checks++; if (got != 200) begin failures++; $display("FAIL rand_budget got=%0d exp=200", got); end
      exp_pop += 16'd200;
      @(negedge clock); out_ready = 1'b0; #1;
      checks++; if (pop_count !== exp_pop) begin failures++; $display("FAIL rand_popcnt got=%0d exp=%0d", pop_count, exp_pop); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rand_busy got=%b exp=0", busy); end
   endtask

   task automatic test_en_drop();
      int done = 0;
      en = 1'b0; out_ready = 1'b1;
      push_one(8'hA5);
      push_one(8'hB6);
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         push_valid = 1'b0;
         en = 1'(c == 0);
         #1;
         checks++; if (fifo_rd !== 1'(c == 0)) begin failures++; $display("FAIL en_rd cyc=%0d got=%b exp=%b", c, fifo_rd, 1'(c == 0)); end
         checks++; if (out_valid !== 1'(c == 2)) begin failures++; $display("FAIL en_valid cyc=%0d got=%b exp=%b", c, out_valid, 1'(c == 2)); end
         if (c == 2) begin
            checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL en_data got=%h exp=a5", out_data); end
         end
      end
      en = 1'b1;
      for (int c = 0; c < 10 && done == 0; c++) begin
         @(negedge clock); #1;
         if (out_valid) begin
            done = 1;
            checks++; if (out_data !== 8'hB6) begin failures++; $display("FAIL en_resume_data got=%h exp=b6", out_data); end
         end
      end
      checks++; if (done != 1) begin failures++; $display("FAIL en_resume_budget got=%0d exp=1", done); end
      exp_pop += 16'd2;
      @(negedge clock); #1;
      checks++; if (pop_count !== exp_pop) begin failures++; $display("FAIL en_popcnt got=%0d exp=%0d", pop_count, exp_pop); end
   endtask

   task automatic test_reset_mid();
      int done = 0;
      en = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 10; i++) push_one(DW'(8'h40 + i));
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         push_valid = 1'b0; en = 1'b1;
         #1;
         checks++; if (fifo_rd !== 1'b1) begin failures++; $display("FAIL rstmid_rd cyc=%0d got=%b exp=1", c, fifo_rd); end
      end
      @(negedge clock); #1;
      checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rstmid_loaded valid=%b busy=%b exp=1/1", out_valid, busy); end
      rst = 1'b1; #1;
      checks++; if (fifo_rd !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_during rd=%b valid=%b busy=%b exp=0/0/0", fifo_rd, out_valid, busy); end
      @(negedge clock);
      rst = 1'b0; exp_pop = '0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      checks++; if (pop_count !== 16'd0) begin failures++; $display("FAIL rstmid_popcnt got=%0d exp=0", pop_count); end
      out_ready = 1'b1;
      push_one(8'h5A);
      for (int c = 0; c < 10 && done == 0; c++) begin
         @(negedge clock);
         push_valid = 1'b0;
         #1;
         if (out_valid) begin
            done = 1;
            checks++; if (out_data !== 8'h5A) begin failures++; $display("FAIL rstmid_data got=%h exp=5a", out_data); end
         end
      end
      checks++; if (done != 1) begin failures++; $display("FAIL rstmid_budget got=%0d exp=1", done); end
      exp_pop += 16'd1;
      @(negedge clock); #1;
      checks++; if (pop_count !== exp_pop) begin failures++; $display("FAIL rstmid_popcnt2 got=%0d exp=%0d", pop_count, exp_pop); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy2 got=%b exp=0", busy); end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_basic();
      test_stall();
      test_random();
      test_en_drop();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
